// File: rtl/bus_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_controller: CPU-side memory/IO controller (RAM, LED register and       |
// | debounced switches) with a fixed IDLE/ACCESS/RESPOND access sequence.      |
// | Optional macro BUS_CYCLE_COUNTER_EN adds a cycle counter at 0xFFF2.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_controller #(
  parameter int RAM_DEPTH       = 4096,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_req,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        bus_error,
  input  logic [3:0]  switches,
  output logic [3:0]  LEDs
);

  localparam int c_RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] c_ADDR_LED = 16'hFFF0;
  localparam logic [15:0] c_ADDR_SW  = 16'hFFF1;
  localparam logic [15:0] c_ADDR_CNT = 16'hFFF2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t             r_state;
  logic [15:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_we;
  logic [1:0]         r_sync [4];
  logic [3:0]         w_debounced;
  logic [31:0]        r_mem [RAM_DEPTH];
  logic [c_RAM_AW-1:0] w_ram_idx;
  logic               w_is_ram;
  logic               w_is_led;
  logic               w_is_sw;
  logic               w_is_cnt;
  logic               w_mapped;
  logic [31:0]        w_cnt_val;

  assign w_ram_idx = r_addr[c_RAM_AW-1:0];
  assign w_is_ram  = ({16'd0, r_addr} < 32'(RAM_DEPTH));
  assign w_is_led  = (r_addr == c_ADDR_LED);
  assign w_is_sw   = (r_addr == c_ADDR_SW);
  assign w_mapped  = w_is_ram | w_is_led | w_is_sw | w_is_cnt;

`ifdef BUS_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;
  assign w_is_cnt  = (r_addr == c_ADDR_CNT);
  assign w_cnt_val = r_cycles;

  // A write clears the counter at the ACCESS edge; it then counts up again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycles <= 32'd0;
    end else if (r_state == S_ACCESS && r_we && w_is_cnt) begin
      r_cycles <= 32'd0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
`else
  assign w_is_cnt  = 1'b0;
  assign w_cnt_val = 32'd0;
`endif

  // RAM has no reset; a reset during ACCESS forces IDLE so no write happens.
  always_ff @(posedge clock) begin
    if (r_state == S_ACCESS && r_we && w_is_ram) begin
      r_mem[w_ram_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= 16'd0;
      r_wdata   <= 32'd0;
      r_we      <= 1'b0;
      cpu_rdata <= 32'd0;
      cpu_ready <= 1'b0;
      bus_error <= 1'b0;
      LEDs      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          cpu_ready <= 1'b0;
          bus_error <= 1'b0;
          if (cpu_req) begin
            r_addr  <= cpu_address;
            r_wdata <= cpu_wdata;
            r_we    <= cpu_we;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cpu_ready <= 1'b1;
          bus_error <= ~w_mapped;
          if (r_we) begin
            cpu_rdata <= 32'd0;
            if (w_is_led) begin
              LEDs <= r_wdata[3:0];
            end
          end else if (w_is_ram) begin
            cpu_rdata <= r_mem[w_ram_idx];
          end else if (w_is_led) begin
            cpu_rdata <= {28'd0, LEDs};
          end else if (w_is_sw) begin
            cpu_rdata <= {28'd0, w_debounced};
          end else if (w_is_cnt) begin
            cpu_rdata <= w_cnt_val;
          end else begin
            cpu_rdata <= 32'd0;
          end
          r_state <= S_RESPOND;
        end
        S_RESPOND: begin
          cpu_ready <= 1'b0;
          bus_error <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          cpu_ready <= 1'b0;
          bus_error <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_switch
      logic              r_deb;
      logic [c_DB_W-1:0] r_cnt;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_sync[gi] <= 2'b00;
        end else begin
          r_sync[gi] <= {r_sync[gi][0], switches[gi]};
        end
      end

      // A change must persist DEBOUNCE_CYCLES cycles before it is accepted.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_deb <= 1'b0;
          r_cnt <= '0;
        end else if (r_sync[gi][1] != r_deb) begin
          if (r_cnt == c_DB_LAST) begin
            r_deb <= r_sync[gi][1];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_debounced[gi] = r_deb;
    end
  endgenerate

endmodule
`default_nettype wire
